// File: rtl/dvi_line_fetch.sv
// dvi_line_fetch: pixel source feeding the DVI timing/serializer stage.
//
// Each active line is fetched from a framebuffer read port into a FWFT pixel
// FIFO while the previous line is in horizontal blanking. The FIFO head is
// presented on phy_r/g/b in the same cycle the timing generator raises vtg_de.
//
// Ports
//   clk_dvi, rst_dvi            pixel clock, asynchronous active-low reset
//   vtg_hcount/vcount/de        current raster position and display enable
//   rd_req_valid/ready/addr     framebuffer read request (pixel address)
//   rd_resp_valid/data          in-order read data {r,g,b}, no backpressure
//   phy_r/g/b                   pixel for the current raster position
//   underrun, clr_underrun      sticky FIFO-empty-during-DE flag and its clear
module dvi_line_fetch #(
  parameter int unsigned H_ACTIVE   = 1280,
  parameter int unsigned V_ACTIVE   = 720,
  parameter int unsigned V_TOTAL    = 750,
  parameter int unsigned FB_BASE    = 0,
  parameter int unsigned STRIDE     = 1280,
  parameter int unsigned ADDR_W     = 22,
  parameter int unsigned FIFO_DEPTH = 2048
) (
  input  logic              clk_dvi,
  input  logic              rst_dvi,
  input  logic [11:0]       vtg_hcount,
  input  logic [11:0]       vtg_vcount,
  input  logic              vtg_de,
  output logic              rd_req_valid,
  input  logic              rd_req_ready,
  output logic [ADDR_W-1:0] rd_req_addr,
  input  logic              rd_resp_valid,
  input  logic [23:0]       rd_resp_data,
  output logic [7:0]        phy_r,
  output logic [7:0]        phy_g,
  output logic [7:0]        phy_b,
  output logic              underrun,
  input  logic              clr_underrun
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned SumW = CntW + 1;

  localparam logic [11:0]       HActive   = 12'(H_ACTIVE);
  localparam logic [11:0]       XLast     = 12'(H_ACTIVE - 1);
  localparam logic [11:0]       VLastLine = 12'(V_TOTAL - 1);
  localparam logic [11:0]       VPrefLim  = 12'(V_ACTIVE - 1);
  localparam logic [ADDR_W-1:0] Base      = ADDR_W'(FB_BASE);
  localparam logic [ADDR_W-1:0] Stride    = ADDR_W'(STRIDE);
  localparam logic [SumW-1:0]   DepthSum  = SumW'(FIFO_DEPTH);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [1:0]        pending_q, pending_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [ADDR_W-1:0] cur_base_q, cur_base_d;
  logic [11:0]       x_req_q, x_req_d;
  logic [CntW-1:0]   out_q, out_d;
  logic [11:0]       discard_q, discard_d;
  logic              underrun_q, underrun_d;

  // FIFO: RAM plus a registered head stage (the FWFT read port)
  logic [23:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   ram_cnt_q, ram_cnt_d;
  logic              head_valid_q, head_valid_d;
  logic [23:0]       head_q;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic            trig, trig_wrap;
  logic            dispatch;
  logic            credit_ok;
  logic            req_fire;
  logic            resp_dec;
  logic            drop, push, pop, load;
  logic            und_evt;
  logic [CntW-1:0] occ;
  logic [SumW-1:0] committed;

  // One trigger per line, at the first blanking pixel of the line before the
  // target line. The last blanking line prefetches line 0 of the next frame.
  assign trig_wrap = (vtg_vcount == VLastLine);
  assign trig      = (vtg_hcount == HActive) && (trig_wrap || (vtg_vcount < VPrefLim));

  // Occupancy counts the head register as well as the RAM.
  assign occ       = ram_cnt_q + CntW'(head_valid_q);
  // Every accepted request owns a FIFO slot until its pixel is popped or
  // dropped, so the FIFO can never overflow.
  assign committed = SumW'(occ) + SumW'(out_q);
  assign credit_ok = (committed < DepthSum);

  assign rd_req_valid = (state_q == StIssue) && credit_ok;
  assign req_fire     = rd_req_valid && rd_req_ready;
  assign rd_req_addr  = cur_base_q + ADDR_W'(x_req_q);

  assign resp_dec = rd_resp_valid && (out_q != '0);
  // Responses owed to pixels already replaced by zeros are dropped so that
  // later lines stay aligned with the raster.
  assign drop     = rd_resp_valid && (discard_q != '0);
  assign push     = rd_resp_valid && (discard_q == '0);

  assign und_evt  = vtg_de && !head_valid_q;
  assign pop      = vtg_de && head_valid_q;
  assign load     = (ram_cnt_q != '0) && (!head_valid_q || pop);

  always_comb begin
    line_base_d = line_base_q;
    if (trig) begin
      line_base_d = trig_wrap ? Base : (line_base_q + Stride);
    end
  end

  always_comb begin
    pending_d = pending_q;
    if (trig && !dispatch) begin
      if (pending_q != 2'd3) begin
        pending_d = pending_q + 2'd1;
      end
    end else if (!trig && dispatch) begin
      pending_d = pending_q - 2'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    x_req_d    = x_req_q;
    cur_base_d = cur_base_q;
    dispatch   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pending_q != 2'd0) begin
          dispatch   = 1'b1;
          state_d    = StIssue;
          x_req_d    = '0;
          cur_base_d = line_base_q;
        end
      end
      StIssue: begin
        if (req_fire) begin
          x_req_d = x_req_q + 12'd1;
          if (x_req_q == XLast) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_d = out_q + CntW'(req_fire) - CntW'(resp_dec);

    discard_d = discard_q;
    if (und_evt && !drop) begin
      if (discard_q != 12'hFFF) begin
        discard_d = discard_q + 12'd1;
      end
    end else if (!und_evt && drop) begin
      discard_d = discard_q - 12'd1;
    end

    // A new underrun beats a simultaneous clear.
    underrun_d = underrun_q;
    if (und_evt) begin
      underrun_d = 1'b1;
    end else if (clr_underrun) begin
      underrun_d = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q + PtrW'(push);
    rd_ptr_d     = rd_ptr_q + PtrW'(load);
    ram_cnt_d    = ram_cnt_q + CntW'(push) - CntW'(load);
    head_valid_d = head_valid_q;
    if (load) begin
      head_valid_d = 1'b1;
    end else if (pop) begin
      head_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_dvi or negedge rst_dvi) begin
    if (!rst_dvi) begin
      state_q      <= StIdle;
      pending_q    <= '0;
      line_base_q  <= Base;
      cur_base_q   <= Base;
      x_req_q      <= '0;
      out_q        <= '0;
      discard_q    <= '0;
      underrun_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ram_cnt_q    <= '0;
      head_valid_q <= 1'b0;
      head_q       <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      line_base_q  <= line_base_d;
      cur_base_q   <= cur_base_d;
      x_req_q      <= x_req_d;
      out_q        <= out_d;
      discard_q    <= discard_d;
      underrun_q   <= underrun_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ram_cnt_q    <= ram_cnt_d;
      head_valid_q <= head_valid_d;
      if (load) begin
        head_q <= mem_q[rd_ptr_q];
      end
    end
  end

  always_ff @(posedge clk_dvi) begin
    if (push) begin
      mem_q[wr_ptr_q] <= rd_resp_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Underrun pixels are black; outside DE the last head value is held.
  always_comb begin
    {phy_r, phy_g, phy_b} = head_q;
    if (und_evt) begin
      {phy_r, phy_g, phy_b} = 24'h0;
    end
  end

  assign underrun = underrun_q;

endmodule

// File: doc/dvi_line_fetch.md
Name: dvi_line_fetch

Overview:
- Pixel source directly upstream of the DVI timing/serializer stage.
- Prefetches each active line from a framebuffer read port into a FWFT pixel FIFO during the preceding horizontal blanking.
- Drives phy_r/g/b aligned to the timing generator's hcount/vcount/de.
- Single clock domain (pixel clock); the memory read port is assumed already in that domain.

Parameters:
- H_ACTIVE, 1280, active pixels per line.
- V_ACTIVE, 720, active lines per frame.
- V_TOTAL, 750, total lines per frame, including blanking.
- FB_BASE, 0, pixel address of frame line 0, pixel 0.
- STRIDE, 1280, address increment per line, in pixels.
- ADDR_W, 22, read address width.
- FIFO_DEPTH, 2048, pixel FIFO entries; power of two, ≥ H_ACTIVE.

Ports:
- clk_dvi  in  1  pixel clock.
- rst_dvi  in  1  asynchronous, active-low reset.
- vtg_hcount  in  12  current x from timing generator.
- vtg_vcount  in  12  current y from timing generator.
- vtg_de  in  1  display enable for the current (x, y).
- rd_req_valid  out  1  read request valid.
- rd_req_ready  in  1  read request accepted.
- rd_req_addr  out  ADDR_W  pixel address.
- rd_resp_valid  in  1  read data valid; in-order, no backpressure.
- rd_resp_data  in  24  {r,g,b}, 8 bits each.
- phy_r  out  8  red for the current pixel.
- phy_g  out  8  green for the current pixel.
- phy_b  out  8  blue for the current pixel.
- underrun  out  1  sticky underrun flag.
- clr_underrun  in  1  clears underrun.

Behaviour:
Reset (rst_dvi low, async)
- rd_req_valid=0, rd_req_addr=FB_BASE, phy_r/g/b=0, underrun=0.
- FIFO empty; all counters 0; FSM in IDLE.

Fetch trigger
- Condition: hcount==H_ACTIVE and (vcount==V_TOTAL-1 or vcount<V_ACTIVE-1).
- Target line = 0 if vcount==V_TOTAL-1, else vcount+1.
- line_base = FB_BASE + target*STRIDE, computed incrementally: load FB_BASE on the V_TOTAL-1 trigger, add STRIDE on the others.
- Triggers are queued in a 2-bit lines_pending counter, saturating at 3.

FSM
- IDLE: if lines_pending>0 → ISSUE. Decrement lines_pending, x_req=0, latch line_base.
- ISSUE:
  - rd_req_valid=1 only when occupancy+outstanding < FIFO_DEPTH (credit check).
  - rd_req_addr = latched_base + x_req.
  - On valid&&ready: x_req++, outstanding++.
  - After accepting request x_req==H_ACTIVE-1 → IDLE. If lines_pending>0, start the next line on the following cycle.
  - rd_req_addr must be stable while valid && !ready.
- Simultaneous trigger during ISSUE: only increments lines_pending; the current line is never aborted.

Response path
- On rd_resp_valid: outstanding--.
- If discard>0: discard--, data dropped. Otherwise push to FIFO.
- The credit check guarantees the FIFO never overflows.

Output path
- phy_{r,g,b} = FIFO head, combinational from the registered FIFO read port (FWFT), so data is valid in the same cycle vtg_de is high.
- vtg_de && !empty: pop.
- vtg_de && empty (underrun): drive 0, underrun<=1, discard++. This keeps subsequent pixels aligned.
- !vtg_de: outputs hold the head value; no pop.
- clr_underrun clears the flag. Underrun set in the same cycle wins.

Arithmetic and widths
- Counters sized to FIFO_DEPTH; occupancy range 0..FIFO_DEPTH.
- discard is 12 bits and saturates.
- outstanding plus occupancy never exceeds FIFO_DEPTH.

Reset mid-operation
- Returns to the reset state regardless of in-flight requests.
- Memory-side responses after reset are the integrator's responsibility. The memory port shares this reset.

Test Plan:
- Setup: H_ACTIVE=8, V_ACTIVE=4, V_TOTAL=6, STRIDE=8, FB_BASE=0x100. Memory returns data=address, 1-cycle latency, ready=1.
  - 2 frames → pixel (x,y) on phy = 0x100+8y+x; underrun stays 0.
- Same setup with rd_req_ready 50% random, response latency 20 cycles → identical pixel stream; rd_req_addr stable under stall.
- Memory stops responding for line 2 → line 2 outputs 0, underrun=1.
  - Late line-2 data discarded; line 3 shows 0x118..0x11F correctly.
  - clr_underrun → 0.
- Frame wrap → first request after the vcount==5 trigger is 0x100; address sequence repeats every frame.
- Reset asserted mid-ISSUE (x_req=4) → outputs 0 and rd_req_valid 0 immediately.
  - After release, next frame's output is correct from line 0.
- FIFO_DEPTH=8, memory 0-latency → occupancy+outstanding never exceeds 8; no pushes lost.
